// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver that assembles BYTE_NUM bytes into one frame word with done/error pulses.
// Optional build macro UART_RX_CHECKSUM_EN: the last byte must equal the mod-256 sum of the others.
`timescale 1ns/1ps

module uart_frame_receiver #(
    parameter int CLK_FS       = 24000000,
    parameter int UART_BPS     = 460800,
    parameter int BPS_CNT      = CLK_FS / UART_BPS,
    parameter int BYTE_NUM     = 11,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  rxd,
    output logic [8*BYTE_NUM-1:0] rxd_data,
    output logic                  rxd_done,
    output logic                  rxd_err
);

    localparam int GAP_MAX = TIMEOUT_BITS * BPS_CNT;
    localparam int CLK_W   = $clog2(BPS_CNT);
    localparam int GAP_W   = $clog2(GAP_MAX);
    localparam int IDX_W   = $clog2(BYTE_NUM);

    localparam logic [CLK_W-1:0] SAMPLE_PT = CLK_W'(BPS_CNT / 2);
    localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(BPS_CNT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_MAX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTE_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t state, state_next;

    logic                      rxd_sync1, rxd_sync2, rxd_prev;
    logic [CLK_W-1:0]          clk_cnt;
    logic [GAP_W-1:0]          gap_cnt;
    logic [2:0]                bit_cnt;
    logic [7:0]                shift;
    logic [IDX_W-1:0]          byte_idx;
    logic [8*(BYTE_NUM-1)-1:0] frame_buf;

    logic start_edge, sample, byte_ok, frame_end, frame_err, timeout, checksum_ok;

`ifdef UART_RX_CHECKSUM_EN
    logic [7:0] sum_acc;
`endif

    assign start_edge = rxd_prev & ~rxd_sync2;
    assign sample     = (clk_cnt == SAMPLE_PT);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_next;
    end

    // Next state plus the single-cycle strobes that drive the datapath below.
    always_comb begin
        state_next  = state;
        byte_ok     = 1'b0;
        frame_err   = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) state_next = START;
                else if (byte_idx != '0 && gap_cnt == GAP_LAST) timeout = 1'b1;
            end
            START: begin
                if (sample) state_next = rxd_sync2 ? IDLE : DATA;
            end
            DATA: begin
                if (sample && bit_cnt == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (sample) begin
                    if (rxd_sync2) begin
                        state_next = IDLE;
                        byte_ok    = 1'b1;
                    end else begin
                        state_next = WAIT_HIGH;
                        frame_err  = 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxd_sync2) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        frame_end = byte_ok && (byte_idx == IDX_LAST);
`ifdef UART_RX_CHECKSUM_EN
        checksum_ok = (shift == sum_acc);
`else
        checksum_ok = 1'b1;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_sync1 <= 1'b1;
            rxd_sync2 <= 1'b1;
            rxd_prev  <= 1'b1;
            clk_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_idx  <= '0;
            frame_buf <= '0;
            rxd_data  <= '0;
            rxd_done  <= 1'b0;
            rxd_err   <= 1'b0;
`ifdef UART_RX_CHECKSUM_EN
            sum_acc   <= '0;
`endif
        end else begin
            rxd_sync1 <= rxd;
            rxd_sync2 <= rxd_sync1;
            rxd_prev  <= rxd_sync2;
            rxd_done  <= 1'b0;
            rxd_err   <= 1'b0;

            // Bit timing restarts from zero on every detected start edge.
            if (state == IDLE || state == WAIT_HIGH || clk_cnt == CLK_LAST) clk_cnt <= '0;
            else                                                            clk_cnt <= clk_cnt + 1'b1;

            if (state == IDLE && byte_idx != '0 && !start_edge && !timeout) gap_cnt <= gap_cnt + 1'b1;
            else                                                            gap_cnt <= '0;

            if (state == START) begin
                bit_cnt <= '0;
            end else if (state == DATA && sample) begin
                shift[bit_cnt] <= rxd_sync2;
                bit_cnt        <= bit_cnt + 3'd1;
            end

            if (timeout || frame_err) begin
                rxd_err  <= 1'b1;
                byte_idx <= '0;
            end

            // The last byte goes straight to the output; earlier ones are buffered.
            if (byte_ok) begin
                if (frame_end) begin
                    byte_idx <= '0;
                    if (checksum_ok) begin
                        rxd_data <= {shift, frame_buf};
                        rxd_done <= 1'b1;
                    end else begin
                        rxd_err  <= 1'b1;
                    end
                end else begin
                    frame_buf[{byte_idx, 3'b000} +: 8] <= shift;
                    byte_idx <= byte_idx + 1'b1;
`ifdef UART_RX_CHECKSUM_EN
                    sum_acc  <= (byte_idx == '0) ? shift : sum_acc + shift;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver: frames, false start, framing error, timeout, reset.
// Build with UART_RX_CHECKSUM_EN defined to exercise the checksum variant instead.
`timescale 1ns/1ps

module tb_uart_frame_receiver;

    localparam int BPS = 52;
    localparam int BN  = 11;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          rxd       = 1'b1;
    logic [8*BN-1:0] rxd_data;
    logic          rxd_done;
    logic          rxd_err;

    int checks    = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int stray_cnt = 0;
    logic [8*BN-1:0] prev_data = '0;
    logic [8*BN-1:0] frame;

    always #5 sys_clk = ~sys_clk;

    uart_frame_receiver dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rxd       (rxd),
        .rxd_data  (rxd_data),
        .rxd_done  (rxd_done),
        .rxd_err   (rxd_err)
    );

    // Pulse monitor; also flags rxd_data moving outside a done cycle.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rxd_done) done_cnt++;
            if (rxd_err) err_cnt++;
            if (rxd_done && rxd_err) both_cnt++;
            if (rxd_data !== prev_data && !rxd_done) stray_cnt++;
        end
        prev_data = rxd_data;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8*BN-1:0] obs, input logic [8*BN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        wait_clks(BPS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clks(BPS);
        end
        rxd = stop_bit;
        wait_clks(BPS);
        rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [8*BN-1:0] f);
        for (int k = 0; k < BN; k++) send_byte(f[8*k +: 8], 1'b1);
        wait_clks(5);
    endtask

    initial begin
        wait_clks(5);
        check("reset_data", rxd_data, '0);
        check("reset_done", {87'd0, rxd_done}, '0);
        check("reset_err", {87'd0, rxd_err}, '0);
        sys_rst_n = 1'b1;
        wait_clks(5);
        check("post_reset_data", rxd_data, '0);

`ifdef UART_RX_CHECKSUM_EN
        frame = {8'h0A, {10{8'h01}}};
        send_frame(frame);
        check("cks_good_done", done_cnt, 1);
        check("cks_good_err", err_cnt, 0);
        check("cks_good_data", rxd_data, frame);

        send_frame({8'h0B, {10{8'h01}}});
        check("cks_bad_done", done_cnt, 1);
        check("cks_bad_err", err_cnt, 1);
        check("cks_bad_data_held", rxd_data, frame);
`else
        // Back-to-back frame 0x00..0x0A.
        send_frame(88'h0A09080706050403020100);
        check("frame1_done", done_cnt, 1);
        check("frame1_err", err_cnt, 0);
        check("frame1_data", rxd_data, 88'h0A09080706050403020100);

        // Short low glitch; waiting past the timeout proves no byte was counted.
        rxd = 1'b0;
        wait_clks(10);
        rxd = 1'b1;
        wait_clks(1100);
        check("glitch_done", done_cnt, 1);
        check("glitch_err", err_cnt, 0);
        check("glitch_data", rxd_data, 88'h0A09080706050403020100);

        // Framing error after three good bytes, then a clean frame.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        wait_clks(BPS);
        check("framing_err", err_cnt, 1);
        check("framing_no_done", done_cnt, 1);
        send_frame({11{8'h55}});
        check("frame55_done", done_cnt, 2);
        check("frame55_err", err_cnt, 1);
        check("frame55_data", rxd_data, {11{8'h55}});

        // Partial frame of five bytes, then an idle gap long enough to time out.
        for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b1);
        wait_clks(1000);
        check("timeout_not_early", err_cnt, 1);
        wait_clks(40);
        check("timeout_err", err_cnt, 2);
        check("timeout_no_done", done_cnt, 2);
        send_frame({11{8'hA5}});
        check("frameA5_done", done_cnt, 3);
        check("frameA5_err", err_cnt, 2);
        check("frameA5_data", rxd_data, {11{8'hA5}});

        // Reset during bit 4 of byte 6.
        for (int k = 0; k < 6; k++) send_byte(8'h60 + 8'(k), 1'b1);
        rxd = 1'b0;
        wait_clks(BPS);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            wait_clks(BPS);
        end
        rxd = 1'b1;
        wait_clks(BPS / 2);
        sys_rst_n = 1'b0;
        #2;
        check("midreset_data", rxd_data, '0);
        check("midreset_done", {87'd0, rxd_done}, '0);
        check("midreset_err", {87'd0, rxd_err}, '0);
        wait_clks(5);
        sys_rst_n = 1'b1;
        wait_clks(5);
        send_frame(88'h1A191817161514131211_10);
        check("after_reset_done", done_cnt, 4);
        check("after_reset_err", err_cnt, 2);
        check("after_reset_data", rxd_data, 88'h1A191817161514131211_10);
`endif

        check("done_err_overlap", both_cnt, 0);
        check("data_change_without_done", stray_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
